adc_scan_ctrl: RTL and testbench

Multi-channel scan sequencer for the ACM9226 front end. It drives the analog-mux select lines and walks through a programmable set of enabled channels. After each switch it discards samples while the mux and ADC pipeline settle, then averages 2^AVG_LOG2 samples and emits one tagged 16-bit result per channel. It sits between the ADC sample clock domain (one clock, same as the ADC sample clock) and the downstream result consumer, and replaces free-running channel switching with a deterministic, masked, settle-aware schedule.

---
 rtl/adc_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : adc_scan_ctrl
//  Description : Multi-channel ADC scan sequencer. Walks the enabled mux
//                channels in ascending order, discards samples while the mux
//                and ADC pipeline settle, averages 2^AVG_LOG2 samples and
//                emits one tagged 16-bit result per channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int SETTLE   = 4,
    parameter int AVG_LOG2 = 2
) (
    input  logic              scan_Clk,
    input  logic              scan_Rst,
    input  logic              scan_En,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [11:0]       adc_in,
    output logic [3:0]        ch_sel,
    output logic [15:0]       res_data,
    output logic [3:0]        res_ch,
    output logic              res_valid,
    output logic              scan_done,
    output logic              busy
);

    localparam int         c_ACC_W       = 12 + AVG_LOG2;
    localparam logic [7:0] c_SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0] c_ACC_LAST    = 8'((1 << AVG_LOG2) - 1);
    localparam logic [3:0] c_PTR_INIT    = 4'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_SETTLE = 3'd2,
        S_ACCUM  = 3'd3,
        S_OUTPUT = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_ptr;
    logic [7:0]           r_cnt;
    logic [c_ACC_W-1:0]   r_acc;
    logic [3:0]           r_ch_sel;
    logic [15:0]          r_res_data;
    logic [3:0]           r_res_ch;
    logic                 r_res_valid;
    logic                 r_scan_done;

    logic                 w_run;
    logic                 w_any_above;
    logic [3:0]           w_hi_idx;
    logic [3:0]           w_lo_idx;
    logic [3:0]           w_next_ch;
    logic [c_ACC_W-1:0]   w_acc_sum;
    logic [c_ACC_W-1:0]   w_avg;

    assign w_run     = scan_En && (ch_mask != '0);
    assign w_acc_sum = r_acc + c_ACC_W'(adc_in);
    assign w_avg     = w_acc_sum >> AVG_LOG2;

    // Lowest enabled channel above the pointer, and lowest enabled overall
    // for the wrap-around; an empty mask leaves the pointer where it is.
    always_comb begin
        w_any_above = 1'b0;
        w_hi_idx    = r_ptr;
        w_lo_idx    = r_ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                w_lo_idx = 4'(i);
                if (4'(i) > r_ptr) begin
                    w_hi_idx    = 4'(i);
                    w_any_above = 1'b1;
                end
            end
        end
    end

    assign w_next_ch = w_any_above ? w_hi_idx : w_lo_idx;

    // State register.
    always_ff @(posedge scan_Clk or negedge scan_Rst) begin
        if (!scan_Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: one channel is always completed once started.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_run) w_state_nxt = S_SELECT;
            S_SELECT: w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_cnt == c_SETTLE_LAST) w_state_nxt = S_ACCUM;
            S_ACCUM:  if (r_cnt == c_ACC_LAST) w_state_nxt = S_OUTPUT;
            S_OUTPUT: w_state_nxt = w_run ? S_SELECT : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: pointer, counters, accumulator and registered result outputs.
    // Results are registered on the last ACCUM edge so they are visible for
    // exactly the OUTPUT cycle.
    always_ff @(posedge scan_Clk or negedge scan_Rst) begin
        if (!scan_Rst) begin
            r_ptr       <= c_PTR_INIT;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_ch_sel    <= '0;
            r_res_data  <= '0;
            r_res_ch    <= '0;
            r_res_valid <= 1'b0;
            r_scan_done <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            r_scan_done <= 1'b0;
            case (r_state)
                S_SELECT: begin
                    r_ptr    <= w_next_ch;
                    r_ch_sel <= w_next_ch;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end
                S_SETTLE: begin
                    if (r_cnt == c_SETTLE_LAST) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_ACCUM: begin
                    r_acc <= w_acc_sum;
                    if (r_cnt == c_ACC_LAST) begin
                        r_res_valid <= 1'b1;
                        r_res_data  <= {4'b0000, w_avg[11:0]};
                        r_res_ch    <= r_ptr;
                        r_scan_done <= ~w_any_above;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_OUTPUT: begin
                    // Leaving for IDLE: next sweep restarts at lowest channel.
                    if (!w_run) r_ptr <= c_PTR_INIT;
                end
                default: ;
            endcase
        end
    end

    assign ch_sel    = r_ch_sel;
    assign res_data  = r_res_data;
    assign res_ch    = r_res_ch;
    assign res_valid = r_res_valid;
    assign scan_done = r_scan_done;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_scan_ctrl
//  Description : Directed self-checking bench for adc_scan_ctrl with a
//                result scoreboard (channel, data, done flag, arrival cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_ctrl;

    localparam int c_PERIOD    = 10;   // 1 + SETTLE + 2^AVG_LOG2 + 1
    localparam int c_ACC_FIRST = 5;    // first ACCUM cycle within a period
    localparam int c_ACC_LAST  = 8;

    logic        scan_Clk = 1'b0;
    logic        scan_Rst;
    logic        scan_En;
    logic [3:0]  ch_mask;
    logic [11:0] adc_in;
    logic [3:0]  ch_sel;
    logic [15:0] res_data;
    logic [3:0]  res_ch;
    logic        res_valid;
    logic        scan_done;
    logic        busy;

    typedef struct packed {
        logic [3:0]  ch;
        logic [15:0] data;
        logic        done;
        logic [31:0] cyc;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   t0          = 0;
    int   mode        = 0;
    int   bad_sel     = 0;
    int   watch_sel   = 0;
    int   busy_cnt    = 0;

    adc_scan_ctrl #(.NUM_CH(4), .SETTLE(4), .AVG_LOG2(2)) dut (
        .scan_Clk  (scan_Clk),
        .scan_Rst  (scan_Rst),
        .scan_En   (scan_En),
        .ch_mask   (ch_mask),
        .adc_in    (adc_in),
        .ch_sel    (ch_sel),
        .res_data  (res_data),
        .res_ch    (res_ch),
        .res_valid (res_valid),
        .scan_done (scan_done),
        .busy      (busy)
    );

    always #5 scan_Clk = ~scan_Clk;

    always @(posedge scan_Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ADC model: value presented during the cycle that follows each edge.
    always @(posedge scan_Clk) begin
        int rel;
        #2;
        rel = (cyc - t0) % c_PERIOD;
        case (mode)
            0:       adc_in = 12'(100 * (int'(ch_sel) + 1));
            1:       adc_in = (rel >= c_ACC_FIRST && rel <= c_ACC_LAST) ?
                              12'(10 + rel - c_ACC_FIRST) : 12'd999;
            default: adc_in = 12'd4095;
        endcase
    end

    // Result monitor / scoreboard consumer.
    always @(posedge scan_Clk) begin
        exp_t e;
        #1;
        if (watch_sel != 0 && busy && (ch_sel == 4'd1 || ch_sel == 4'd3)) bad_sel++;
        if (scan_done) chk("done_w_valid", 32'(res_valid), 32'd1);
        if (res_valid) begin
            vectors++;
            assert (q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_result: observed ch %0d data %0d expected none", res_ch, res_data);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("res_ch",    32'(res_ch),    32'(e.ch));
                chk("res_data",  32'(res_data),  32'(e.data));
                chk("scan_done", 32'(scan_done), 32'(e.done));
                chk("res_time",  32'(cyc),       e.cyc);
            end
        end
    end

    task automatic start();
        scan_En = 1'b1;
        t0      = cyc + 1;
    endtask

    task automatic expect_res(input int ch, input int data, input int done, input int k);
        exp_t e;
        e.ch   = 4'(ch);
        e.data = 16'(data);
        e.done = 1'(done);
        e.cyc  = 32'(t0 + c_PERIOD - 1 + c_PERIOD * k);
        q.push_back(e);
    endtask

    task automatic drain_and_stop(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) @(negedge scan_Clk);
        chk("drain", 32'(q.size()), 32'd0);
        scan_En = 1'b0;
        @(negedge scan_Clk);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic wait_rel(input int rel);
        for (int i = 0; i < 100 && cyc < t0 + rel; i++) @(negedge scan_Clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ch_sel"},    32'(ch_sel),    32'd0);
        chk({tag, "_res_data"},  32'(res_data),  32'd0);
        chk({tag, "_res_ch"},    32'(res_ch),    32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_scan_done"}, 32'(scan_done), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        scan_Rst = 1'b0;
        scan_En  = 1'b0;
        ch_mask  = 4'b0000;
        adc_in   = 12'd0;
        repeat (3) @(negedge scan_Clk);
        chk_zero("reset");
        scan_Rst = 1'b1;
        @(negedge scan_Clk);

        // Full sweep, all channels enabled.
        ch_mask = 4'b1111;
        mode    = 0;
        start();
        expect_res(0, 100, 0, 0);
        expect_res(1, 200, 0, 1);
        expect_res(2, 300, 0, 2);
        expect_res(3, 400, 1, 3);
        expect_res(0, 100, 0, 4);
        @(negedge scan_Clk);
        chk("busy_up", 32'(busy), 32'd1);
        drain_and_stop(80);

        // Averaging with settle samples that must be ignored.
        ch_mask = 4'b0001;
        mode    = 1;
        start();
        expect_res(0, 11, 1, 0);
        expect_res(0, 11, 1, 1);
        drain_and_stop(40);

        // Full-scale input: no overflow.
        mode = 2;
        start();
        expect_res(0, 4095, 1, 0);
        drain_and_stop(30);

        // Sparse mask: channels 1 and 3 must never be selected.
        ch_mask   = 4'b0101;
        mode      = 0;
        bad_sel   = 0;
        watch_sel = 1;
        start();
        expect_res(0, 100, 0, 0);
        expect_res(2, 300, 1, 1);
        expect_res(0, 100, 0, 2);
        expect_res(2, 300, 1, 3);
        drain_and_stop(60);
        watch_sel = 0;
        chk("sel_skip", 32'(bad_sel), 32'd0);

        // Empty mask with enable high: stays idle.
        ch_mask  = 4'b0000;
        scan_En  = 1'b1;
        busy_cnt = 0;
        repeat (15) begin
            @(negedge scan_Clk);
            if (busy) busy_cnt++;
        end
        chk("mask0_busy", 32'(busy_cnt), 32'd0);
        scan_En = 1'b0;
        @(negedge scan_Clk);

        // Drop enable mid-SETTLE on ch1: ch1 still completes, then idle.
        ch_mask = 4'b1111;
        start();
        expect_res(0, 100, 0, 0);
        expect_res(1, 200, 0, 1);
        wait_rel(12);
        scan_En = 1'b0;
        drain_and_stop(40);
        start();
        expect_res(0, 100, 0, 0);
        drain_and_stop(30);

        // Reset in the middle of ch1 accumulation.
        start();
        expect_res(0, 100, 0, 0);
        wait_rel(16);
        scan_Rst = 1'b0;
        #1;
        chk_zero("midrst");
        chk("midrst_pending", 32'(q.size()), 32'd0);
        @(negedge scan_Clk);
        @(negedge scan_Clk);
        scan_Rst = 1'b1;
        start();
        expect_res(0, 100, 0, 0);
        drain_and_stop(30);

        repeat (3) @(negedge scan_Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
